// File: rtl/prio_req_tracker.sv
`default_nettype none
// ============================================================================
// Module   : prio_req_tracker
// Brief    : Sticky request tracker; offers the highest pending line on a
//            valid/ready port and clears it on accept.
// Revision : 1.0
// ============================================================================
module prio_req_tracker #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    input  logic             clr_all,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_idx,
    output logic [WIDTH-1:0] pending,
    output logic             overflow
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pending;
    logic [IDXW-1:0]  r_out_idx;
    logic             r_overflow;

    logic             w_accept;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_pending_next;
    logic             w_overflow_next;
    logic [IDXW-1:0]  w_next_idx;

    assign w_accept        = (r_state == ST_OFFER) && out_ready;
    assign w_clr           = w_accept ? ({{(WIDTH-1){1'b0}}, 1'b1} << r_out_idx) : '0;
    // A re-request on the line being accepted survives and is not a duplicate.
    assign w_pending_next  = (r_pending & ~w_clr) | req_in;
    assign w_overflow_next = |(req_in & r_pending & ~w_clr);

    // Highest set bit wins: later iterations overwrite lower indices.
    always_comb begin
        w_next_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_pending_next[i]) begin
                w_next_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_out_idx  <= '0;
            r_overflow <= 1'b0;
        end else if (clr_all) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending_next) begin
                        r_state   <= ST_OFFER;
                        r_out_idx <= w_next_idx;
                    end
                end
                ST_OFFER: begin
                    // No preemption: the index only moves on accept.
                    if (w_accept) begin
                        if (|w_pending_next) begin
                            r_out_idx <= w_next_idx;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == ST_OFFER);
    assign out_idx   = r_out_idx;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_prio_req_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_req_tracker
// Brief    : Self-checking bench for prio_req_tracker.
// Revision : 1.0
// ============================================================================
module tb_prio_req_tracker;

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic       clr_all;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic       overflow;

    int n_chk;
    int n_fail;

    // Reference state
    logic [7:0] m_pend;
    logic       m_valid;
    int         m_idx;
    logic       m_ovf;

    typedef struct {
        logic [7:0] req;
        logic       clr;
        logic       rdy;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] ep;
        logic       eo;
    } vec_t;

    vec_t tbl[16];

    prio_req_tracker #(.WIDTH(8), .IDXW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .clr_all   (clr_all),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock of behaviour, written line by line from the rules
    task automatic model_step(input logic [7:0] r, input logic c, input logic rd);
        bit accepted;
        bit dup;
        bit found;
        if (c) begin
            m_pend  = 8'h00;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            accepted = m_valid && rd;
            dup      = 0;
            for (int i = 0; i < 8; i++) begin
                if (r[i] && m_pend[i] && !(accepted && i == m_idx)) dup = 1;
            end
            if (accepted) m_pend[m_idx] = 1'b0;
            for (int i = 0; i < 8; i++) if (r[i]) m_pend[i] = 1'b1;
            m_ovf = dup;
            if (!m_valid || accepted) begin
                found = 0;
                for (int i = 7; i >= 0; i--) begin
                    if (!found && m_pend[i]) begin
                        found = 1;
                        m_idx = i;
                    end
                end
                m_valid = found;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic c, input logic rd);
        req_in    = r;
        clr_all   = c;
        out_ready = rd;
        @(posedge clk);
        model_step(r, c, rd);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"},    {7'd0, out_valid}, {7'd0, m_valid});
        chk({tag, ".idx"},      {5'd0, out_idx},   8'(m_idx));
        chk({tag, ".pending"},  pending,           m_pend);
        chk({tag, ".overflow"}, {7'd0, overflow},  {7'd0, m_ovf});
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_in    = 8'h00;
        clr_all   = 1'b0;
        out_ready = 1'b0;
        model_reset();

        //            req    clr   rdy   v     idx   pend   ovf
        tbl[0]  = '{8'h92, 1'b0, 1'b1, 1'b1, 3'd7, 8'h92, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h12, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0};
        tbl[4]  = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0};
        tbl[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
        tbl[6]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
        tbl[7]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0};
        tbl[9]  = '{8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0};
        tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0};
        tbl[11] = '{8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 1'b0};
        tbl[12] = '{8'h10, 1'b1, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
        tbl[13] = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0};
        tbl[14] = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
        tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid",    {7'd0, out_valid}, 8'h00);
        chk("reset.idx",      {5'd0, out_idx},   8'h00);
        chk("reset.pending",  pending,           8'h00);
        chk("reset.overflow", {7'd0, overflow},  8'h00);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            step(tbl[k].req, tbl[k].clr, tbl[k].rdy);
            chk($sformatf("vec%0d.valid", k),    {7'd0, out_valid}, {7'd0, tbl[k].ev});
            chk($sformatf("vec%0d.idx", k),      {5'd0, out_idx},   {5'd0, tbl[k].ei});
            chk($sformatf("vec%0d.pending", k),  pending,           tbl[k].ep);
            chk($sformatf("vec%0d.overflow", k), {7'd0, overflow},  {7'd0, tbl[k].eo});
        end

        // No preemption while stalled, then drain in priority order
        step(8'h04, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h80, 1'b0, 1'b0);
        chk("stall.idx",     {5'd0, out_idx}, 8'h02);
        chk("stall.pending", pending,         8'h84);
        chk_model("stall");
        step(8'h00, 1'b0, 1'b1);
        chk("drain1.idx",     {5'd0, out_idx}, 8'h07);
        chk("drain1.pending", pending,         8'h80);
        step(8'h00, 1'b0, 1'b1);
        chk("drain2.valid", {7'd0, out_valid}, 8'h00);
        chk_model("drain2");

        // Asynchronous reset in the middle of an offer
        step(8'hA5, 1'b0, 1'b0);
        chk("preRst.pending", pending, 8'hA5);
        #2 rst = 1'b1;
        #1;
        chk("asyncRst.valid",    {7'd0, out_valid}, 8'h00);
        chk("asyncRst.idx",      {5'd0, out_idx},   8'h00);
        chk("asyncRst.pending",  pending,           8'h00);
        chk("asyncRst.overflow", {7'd0, overflow},  8'h00);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic against the reference
        for (int k = 0; k < 500; k++) begin
            logic [7:0] r;
            logic       c;
            logic       rd;
            r  = 8'($urandom) & 8'($urandom) & ((k % 64) < 32 ? 8'hFF : 8'($urandom));
            c  = ($urandom_range(0, 24) == 0);
            rd = ($urandom_range(0, 3) != 0);
            step(r, c, rd);
            chk_model($sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
